// File: rtl/restoring_divider_pkg.sv
// Shared types and helpers for the restoring divider.
//   state_e   : control FSM states (idle, iterating, result cycle)
//   cnt_width : width of a down-counter that must hold the value n
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/suma_parametrizable.sv
// Structural ripple-carry adder.
//   a, b : N-bit addends
//   cin  : carry in
//   sum  : N-bit sum
//   cout : carry out of the top bit
module suma_parametrizable #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   start       : launch request, accepted in idle or on the result cycle
//   dividend    : numerator, captured on acceptance
//   divisor     : denominator, captured on acceptance
//   quotient    : result quotient, held until the next accepted start
//   remainder   : result remainder, same validity as quotient
//   busy        : high while iterating
//   done        : one-cycle pulse, results valid
//   div_by_zero : captured divisor was zero (quotient all ones, remainder = dividend)
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q, state_d;
  logic [N-1:0]    d_q, d_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    r_q, r_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;

  logic [N:0]      trial;
  logic [N:0]      diff;
  logic            no_borrow;
  logic            diff_msb_unused;

  // Trial subtraction T - D as T + ~D + 1; carry out set means no borrow.
  assign trial = {r_q, q_q[N-1]};

  suma_parametrizable #(
    .N (N + 1)
  ) u_sub (
    .a    (trial),
    .b    (~{1'b0, d_q}),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  // R < D always holds, so a successful subtraction never sets the top bit.
  assign diff_msb_unused = diff[N];

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        if (no_borrow) begin
          r_d = diff[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = trial[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFin;
          quo_d   = q_d;
          rem_d   = r_d;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Acceptance overrides the result-cycle return to idle (back-to-back).
    if (start && (state_q != StRun)) begin
      d_d   = divisor;
      q_d   = dividend;
      r_d   = '0;
      cnt_d = CntW'(N);
      if (divisor != '0) begin
        state_d = StRun;
        quo_d   = '0;
        rem_d   = '0;
        dbz_d   = 1'b0;
      end else begin
        state_d = StFin;
        quo_d   = '1;
        rem_d   = dividend;
        dbz_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StFin);

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

  logic       clk;
  logic       rst;

  logic       st4;
  logic [3:0] a4, b4, q4, r4;
  logic       busy4, done4, z4;

  logic       st8;
  logic [7:0] a8, b8, q8, r8;
  logic       busy8, done8, z8;

  int n_checks;
  int n_pass;

  restoring_divider #(
    .N (4)
  ) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (st4),
    .dividend    (a4),
    .divisor     (b4),
    .quotient    (q4),
    .remainder   (r4),
    .busy        (busy4),
    .done        (done4),
    .div_by_zero (z4)
  );

  restoring_divider #(
    .N (8)
  ) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (st8),
    .dividend    (a8),
    .divisor     (b8),
    .quotient    (q8),
    .remainder   (r8),
    .busy        (busy8),
    .done        (done8),
    .div_by_zero (z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Waits (bounded) for done4; lat is the cycle index after the accepting edge.
  task automatic wait_done4(inout int lat);
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic go4(input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    st4 = 1'b1;
    a4  = a;
    b4  = b;
    @(negedge clk);
    st4 = 1'b0;
    lat = 1;
    wait_done4(lat);
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    st8 = 1'b1;
    a8  = a;
    b8  = b;
    @(negedge clk);
    st8 = 1'b0;
    a8  = ~a;
    b8  = ~b;
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [7:0] ea, eb;
    n_checks = 0;
    n_pass   = 0;
    st4 = 1'b0; a4 = '0; b4 = '0;
    st8 = 1'b0; a8 = '0; b8 = '0;
    rst = 1'b1;
    #1;
    check("reset_q", q4, 0);
    check("reset_r", r4, 0);
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_dbz", z4, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 13/3 with per-cycle busy/done profile
    @(negedge clk);
    st4 = 1'b1; a4 = 4'd13; b4 = 4'd3;
    @(negedge clk);
    st4 = 1'b0; a4 = 4'd1; b4 = 4'd1;
    for (int i = 1; i <= 4; i++) begin
      check("13/3_busy", busy4, 1);
      check("13/3_done_early", done4, 0);
      @(negedge clk);
    end
    check("13/3_done", done4, 1);
    check("13/3_busy_fin", busy4, 0);
    check("13/3_q", q4, 4);
    check("13/3_r", r4, 1);
    check("13/3_dbz", z4, 0);
    repeat (3) @(negedge clk);
    check("13/3_done_pulse", done4, 0);
    check("13/3_hold_q", q4, 4);
    check("13/3_hold_r", r4, 1);

    // divide by zero, then a normal op clears the flag
    go4(4'd7, 4'd0, lat);
    check("7/0_lat", lat, 1);
    check("7/0_q", q4, 15);
    check("7/0_r", r4, 7);
    check("7/0_dbz", z4, 1);
    go4(4'd15, 4'd1, lat);
    check("15/1_lat", lat, 5);
    check("15/1_q", q4, 15);
    check("15/1_r", r4, 0);
    check("15/1_dbz", z4, 0);

    // back-to-back: start held during the result cycle
    go4(4'd2, 4'd9, lat);
    check("2/9_lat", lat, 5);
    check("2/9_q", q4, 0);
    check("2/9_r", r4, 2);
    st4 = 1'b1; a4 = 4'd0; b4 = 4'd5;
    @(negedge clk);
    st4 = 1'b0;
    check("b2b_done_pulse", done4, 0);
    check("b2b_busy", busy4, 1);
    lat = 1;
    wait_done4(lat);
    check("0/5_lat", lat, 5);
    check("0/5_q", q4, 0);
    check("0/5_r", r4, 0);

    // restart during RUN is ignored, inputs change mid-run
    @(negedge clk);
    st4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
    @(negedge clk);
    st4 = 1'b0;
    @(negedge clk);
    st4 = 1'b1; a4 = 4'd9; b4 = 4'd2;
    @(negedge clk);
    st4 = 1'b0; a4 = 4'd3; b4 = 4'd1;
    lat = 3;
    wait_done4(lat);
    check("12/5_lat", lat, 5);
    check("12/5_q", q4, 2);
    check("12/5_r", r4, 2);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("12/5_single_done", ndone, 0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    st4 = 1'b1; a4 = 4'd14; b4 = 4'd3;
    @(negedge clk);
    st4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_q", q4, 0);
    check("rst_r", r4, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 || busy4) ndone++;
    end
    check("rst_no_done", ndone, 0);
    go4(4'd14, 4'd3, lat);
    check("14/3_lat", lat, 5);
    check("14/3_q", q4, 4);
    check("14/3_r", r4, 2);

    // N=8 sweep with corners first
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: begin ea = 8'd255; eb = 8'd255; end
        1: begin ea = 8'd255; eb = 8'd1;   end
        2: begin ea = 8'd0;   eb = 8'd0;   end
        default: begin
          ea = 8'($urandom_range(0, 255));
          eb = (i % 50 == 7) ? 8'd0 : 8'($urandom_range(0, 255));
        end
      endcase
      go8(ea, eb, lat);
      if (eb == 8'd0) begin
        check("n8_lat", lat, 1);
        check("n8_q", q8, 255);
        check("n8_r", r8, ea);
        check("n8_dbz", z8, 1);
      end else begin
        check("n8_lat", lat, 9);
        check("n8_q", q8, ea / eb);
        check("n8_r", r8, ea % eb);
        check("n8_dbz", z8, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
